mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_if.sv | 32 +++
 rtl/mem_access_unit.sv | 155 +++++++++++++++
 tb/tb_mem_access_unit.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Core/memory bus bundle for mem_access_unit: request, response and data-memory sides.
// The slave modport is the unit's view; master is the core plus memory environment.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data, resp_ready,
    output req_ready, mem_write, mem_read, mem_funct3, mem_address, mem_write_data,
           resp_valid, resp_rdata, resp_err
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data, resp_ready,
    input  req_ready, mem_write, mem_read, mem_funct3, mem_address, mem_write_data,
           resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: validates a core request, holds a memory strobe for MEM_LATENCY
// cycles, then presents a response until the core consumes it.
module mem_access_unit #(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned ADDR_LIMIT  = 256
) (
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave bus
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ADDR_W = 32;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE = 2'b10;
  localparam logic [1:0] ERR_F3    = 2'b11;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_we;
  logic                  r_req_ready;
  logic                  r_mem_write;
  logic                  r_mem_read;
  logic [2:0]            r_mem_funct3;
  logic [ADDR_W-1:0]     r_mem_address;
  logic [31:0]           r_mem_write_data;
  logic                  r_resp_valid;
  logic [31:0]           r_resp_rdata;
  logic [1:0]            r_resp_err;

  logic                  w_accept;
  logic                  w_illegal;
  logic                  w_misaligned;
  logic                  w_out_of_range;
  logic [ADDR_W:0]       w_size;
  logic [ADDR_W:0]       w_end;
  logic [1:0]            w_err;

  assign w_accept = bus.req_valid & r_req_ready;

  // Request check, computed on the live request so errors are known at acceptance.
  always_comb begin
    w_illegal = 1'b1;
    if (bus.req_we) begin
      w_illegal = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010});
    end else begin
      w_illegal = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end

    w_size = (ADDR_W+1)'(4);
    case (bus.req_funct3[1:0])
      2'b00:   w_size = (ADDR_W+1)'(1);
      2'b01:   w_size = (ADDR_W+1)'(2);
      default: w_size = (ADDR_W+1)'(4);
    endcase

    w_misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                   ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));

    // One extra bit so an access near 2^32 cannot wrap back into range.
    w_end          = {1'b0, bus.req_addr} + w_size;
    w_out_of_range = w_end > (ADDR_W+1)'(ADDR_LIMIT);

    w_err = ERR_OK;
    if (w_illegal) begin
      w_err = ERR_F3;
    end else if (w_misaligned) begin
      w_err = ERR_ALIGN;
    end else if (w_out_of_range) begin
      w_err = ERR_RANGE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_cnt            <= '0;
      r_we             <= 1'b0;
      r_req_ready      <= 1'b1;
      r_mem_write      <= 1'b0;
      r_mem_read       <= 1'b0;
      r_mem_funct3     <= '0;
      r_mem_address    <= '0;
      r_mem_write_data <= '0;
      r_resp_valid     <= 1'b0;
      r_resp_rdata     <= '0;
      r_resp_err       <= ERR_OK;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we             <= bus.req_we;
            r_mem_funct3     <= bus.req_funct3;
            r_mem_address    <= bus.req_addr;
            r_mem_write_data <= bus.req_wdata;
            r_resp_rdata     <= '0;
            r_resp_err       <= w_err;
            r_req_ready      <= 1'b0;
            if (w_err != ERR_OK) begin
              r_resp_valid <= 1'b1;
              r_state      <= RESP;
            end else begin
              r_cnt       <= CNT_W'(MEM_LATENCY - 1);
              r_mem_write <= bus.req_we;
              r_mem_read  <= !bus.req_we;
              r_state     <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (r_cnt == '0) begin
            r_mem_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_resp_valid <= 1'b1;
            if (!r_we) begin
              r_resp_rdata <= bus.mem_read_data;
            end
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_mem_write  <= 1'b0;
          r_mem_read   <= 1'b0;
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready      = r_req_ready;
  assign bus.mem_write      = r_mem_write;
  assign bus.mem_read       = r_mem_read;
  assign bus.mem_funct3     = r_mem_funct3;
  assign bus.mem_address    = r_mem_address;
  assign bus.mem_write_data = r_mem_write_data;
  assign bus.resp_valid     = r_resp_valid;
  assign bus.resp_rdata     = r_resp_rdata;
  assign bus.resp_err       = r_resp_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: one instance at MEM_LATENCY=1 and one at 3,
// sharing a byte-addressed data memory model that applies funct3 width/sign rules.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst1;
  logic rst3;
  bit   dsel;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_access_unit_if bus1 ();
  mem_access_unit_if bus3 ();

  mem_access_unit #(.MEM_LATENCY(1), .ADDR_LIMIT(256)) u_dut1 (
    .clk (clk), .rst (rst1), .bus (bus1)
  );
  mem_access_unit #(.MEM_LATENCY(3), .ADDR_LIMIT(256)) u_dut3 (
    .clk (clk), .rst (rst3), .bus (bus3)
  );

  logic [7:0] mem [256];
  logic [7:0] a1;
  logic [7:0] a3;
  int         wr_cnt [2];
  int         rd_cnt [2];

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [7:0] b0,
                                           input logic [7:0] b1, input logic [7:0] b2,
                                           input logic [7:0] b3);
    case (f3)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b100:  return {24'h0, b0};
      3'b101:  return {16'h0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  always_comb begin
    a1 = bus1.mem_address[7:0];
    a3 = bus3.mem_address[7:0];
    bus1.mem_read_data = load_ext(bus1.mem_funct3, mem[a1], mem[8'(a1 + 8'd1)],
                                  mem[8'(a1 + 8'd2)], mem[8'(a1 + 8'd3)]);
    bus3.mem_read_data = load_ext(bus3.mem_funct3, mem[a3], mem[8'(a3 + 8'd1)],
                                  mem[8'(a3 + 8'd2)], mem[8'(a3 + 8'd3)]);
  end

  // Memory commit plus per-instance strobe-cycle counters.
  always @(posedge clk) begin
    if (bus1.mem_write) begin
      mem[a1] <= bus1.mem_write_data[7:0];
      if (bus1.mem_funct3[1:0] != 2'b00) mem[8'(a1 + 8'd1)] <= bus1.mem_write_data[15:8];
      if (bus1.mem_funct3[1:0] == 2'b10) begin
        mem[8'(a1 + 8'd2)] <= bus1.mem_write_data[23:16];
        mem[8'(a1 + 8'd3)] <= bus1.mem_write_data[31:24];
      end
    end
    if (bus3.mem_write) begin
      mem[a3] <= bus3.mem_write_data[7:0];
      if (bus3.mem_funct3[1:0] != 2'b00) mem[8'(a3 + 8'd1)] <= bus3.mem_write_data[15:8];
      if (bus3.mem_funct3[1:0] == 2'b10) begin
        mem[8'(a3 + 8'd2)] <= bus3.mem_write_data[23:16];
        mem[8'(a3 + 8'd3)] <= bus3.mem_write_data[31:24];
      end
    end
    wr_cnt[0] <= wr_cnt[0] + (bus1.mem_write ? 1 : 0);
    rd_cnt[0] <= rd_cnt[0] + (bus1.mem_read  ? 1 : 0);
    wr_cnt[1] <= wr_cnt[1] + (bus3.mem_write ? 1 : 0);
    rd_cnt[1] <= rd_cnt[1] + (bus3.mem_read  ? 1 : 0);
  end

  logic        obs_req_ready, obs_resp_valid, obs_mem_write, obs_mem_read;
  logic [31:0] obs_resp_rdata, obs_mem_address, obs_mem_write_data;
  logic [1:0]  obs_resp_err;
  logic [2:0]  obs_mem_funct3;

  always_comb begin
    obs_req_ready      = dsel ? bus3.req_ready      : bus1.req_ready;
    obs_resp_valid     = dsel ? bus3.resp_valid     : bus1.resp_valid;
    obs_mem_write      = dsel ? bus3.mem_write      : bus1.mem_write;
    obs_mem_read       = dsel ? bus3.mem_read       : bus1.mem_read;
    obs_resp_rdata     = dsel ? bus3.resp_rdata     : bus1.resp_rdata;
    obs_resp_err       = dsel ? bus3.resp_err       : bus1.resp_err;
    obs_mem_address    = dsel ? bus3.mem_address    : bus1.mem_address;
    obs_mem_funct3     = dsel ? bus3.mem_funct3     : bus1.mem_funct3;
    obs_mem_write_data = dsel ? bus3.mem_write_data : bus1.mem_write_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic v, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
    if (dsel) begin
      bus3.req_valid = v; bus3.req_we = we; bus3.req_funct3 = f3;
      bus3.req_addr = a;  bus3.req_wdata = d;
    end else begin
      bus1.req_valid = v; bus1.req_we = we; bus1.req_funct3 = f3;
      bus1.req_addr = a;  bus1.req_wdata = d;
    end
  endtask

  task automatic set_resp_ready(input logic r);
    if (dsel) bus3.resp_ready = r;
    else      bus1.resp_ready = r;
  endtask

  // Issue one request; return negedges from acceptance until resp_valid, and strobe cycles.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, output int lat, output int dw, output int dr);
    int idx;
    int w0;
    int r0;
    idx = dsel ? 1 : 0;
    @(negedge clk);
    w0 = wr_cnt[idx];
    r0 = rd_cnt[idx];
    check("req_ready_before_issue", 32'(obs_req_ready), 32'd1);
    set_req(1'b1, we, f3, a, d);
    @(posedge clk);
    #1;
    set_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (obs_resp_valid) break;
    end
    if (!obs_resp_valid) check("resp_valid_timeout", 32'(obs_resp_valid), 32'd1);
    dw = wr_cnt[idx] - w0;
    dr = rd_cnt[idx] - r0;
  endtask

  task automatic consume();
    set_resp_ready(1'b1);
    @(posedge clk);
    #1;
    set_resp_ready(1'b0);
    @(negedge clk);
    check("idle_after_consume_ready", 32'(obs_req_ready), 32'd1);
    check("idle_after_consume_valid", 32'(obs_resp_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int dw;
    int dr;
    int w0;

    rst1 = 1'b1;
    rst3 = 1'b1;
    dsel = 1'b1;
    set_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    set_resp_ready(1'b0);
    dsel = 1'b0;
    set_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    set_resp_ready(1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst1 = 1'b0;
    rst3 = 1'b0;

    @(negedge clk);
    check("rst_req_ready",      32'(obs_req_ready),      32'd1);
    check("rst_resp_valid",     32'(obs_resp_valid),     32'd0);
    check("rst_mem_write",      32'(obs_mem_write),      32'd0);
    check("rst_mem_read",       32'(obs_mem_read),       32'd0);
    check("rst_resp_rdata",     obs_resp_rdata,          32'd0);
    check("rst_resp_err",       32'(obs_resp_err),       32'd0);
    check("rst_mem_address",    obs_mem_address,         32'd0);
    check("rst_mem_funct3",     32'(obs_mem_funct3),     32'd0);
    check("rst_mem_write_data", obs_mem_write_data,      32'd0);

    // SW 0xDEADBEEF to 0x10, then LW it back.
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, dw, dr);
    check("sw_latency", 32'(lat), 32'd2);
    check("sw_err",     32'(obs_resp_err), 32'd0);
    check("sw_rdata",   obs_resp_rdata, 32'd0);
    check("sw_wcycles", 32'(dw), 32'd1);
    check("sw_rcycles", 32'(dr), 32'd0);
    consume();
    check("held_address", obs_mem_address, 32'h10);
    check("held_wdata",   obs_mem_write_data, 32'hDEADBEEF);

    issue(1'b0, 3'b010, 32'h10, 32'h0, lat, dw, dr);
    check("lw_latency", 32'(lat), 32'd2);
    check("lw_err",     32'(obs_resp_err), 32'd0);
    check("lw_rdata",   obs_resp_rdata, 32'hDEADBEEF);
    check("lw_rcycles", 32'(dr), 32'd1);
    check("lw_wcycles", 32'(dw), 32'd0);
    // A request presented while in RESP must be ignored.
    set_req(1'b1, 1'b1, 3'b010, 32'h44, 32'h55);
    @(negedge clk);
    check("busy_req_ready", 32'(obs_req_ready), 32'd0);
    check("busy_rdata_held", obs_resp_rdata, 32'hDEADBEEF);
    check("busy_addr_unlatched", obs_mem_address, 32'h10);
    set_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    consume();

    issue(1'b0, 3'b001, 32'h11, 32'h0, lat, dw, dr);
    check("lh_mis_latency", 32'(lat), 32'd1);
    check("lh_mis_err",     32'(obs_resp_err), 32'd1);
    check("lh_mis_rcycles", 32'(dr), 32'd0);
    check("lh_mis_rdata",   obs_resp_rdata, 32'd0);
    consume();

    // Word at 0xFE is misaligned, which outranks out-of-range.
    issue(1'b0, 3'b010, 32'hFE, 32'h0, lat, dw, dr);
    check("lw_fe_err", 32'(obs_resp_err), 32'd1);
    consume();
    issue(1'b0, 3'b010, 32'hFC, 32'h0, lat, dw, dr);
    check("lw_fc_err",     32'(obs_resp_err), 32'd0);
    check("lw_fc_latency", 32'(lat), 32'd2);
    consume();
    issue(1'b0, 3'b010, 32'h100, 32'h0, lat, dw, dr);
    check("lw_100_err",     32'(obs_resp_err), 32'd2);
    check("lw_100_latency", 32'(lat), 32'd1);
    check("lw_100_rcycles", 32'(dr), 32'd0);
    consume();
    issue(1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0, lat, dw, dr);
    check("lw_wrap_err", 32'(obs_resp_err), 32'd2);
    consume();

    issue(1'b1, 3'b000, 32'hFF, 32'h5A5A5AA5, lat, dw, dr);
    check("sb_ff_err",     32'(obs_resp_err), 32'd0);
    check("sb_ff_wcycles", 32'(dw), 32'd1);
    consume();
    issue(1'b0, 3'b100, 32'hFF, 32'h0, lat, dw, dr);
    check("lbu_ff_rdata", obs_resp_rdata, 32'h000000A5);
    consume();
    issue(1'b0, 3'b000, 32'hFF, 32'h0, lat, dw, dr);
    check("lb_ff_rdata", obs_resp_rdata, 32'hFFFFFFA5);
    consume();

    issue(1'b1, 3'b100, 32'h20, 32'h1234, lat, dw, dr);
    check("st_f3_100_err",     32'(obs_resp_err), 32'd3);
    check("st_f3_100_wcycles", 32'(dw), 32'd0);
    consume();
    issue(1'b0, 3'b011, 32'h20, 32'h0, lat, dw, dr);
    check("ld_f3_011_err",     32'(obs_resp_err), 32'd3);
    check("ld_f3_011_rcycles", 32'(dr), 32'd0);
    consume();
    issue(1'b1, 3'b101, 32'h1FF, 32'h0, lat, dw, dr);
    check("st_f3_101_prio_err", 32'(obs_resp_err), 32'd3);
    consume();

    // MEM_LATENCY = 3 instance.
    dsel = 1'b1;
    issue(1'b1, 3'b000, 32'h20, 32'h00000080, lat, dw, dr);
    check("l3_sb_latency", 32'(lat), 32'd4);
    check("l3_sb_wcycles", 32'(dw), 32'd3);
    consume();
    issue(1'b0, 3'b000, 32'h20, 32'h0, lat, dw, dr);
    check("l3_lb_latency", 32'(lat), 32'd4);
    check("l3_lb_rcycles", 32'(dr), 32'd3);
    check("l3_lb_rdata",   obs_resp_rdata, 32'hFFFFFF80);
    check("l3_lb_err",     32'(obs_resp_err), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("l3_hold_valid", 32'(obs_resp_valid), 32'd1);
      check("l3_hold_rdata", obs_resp_rdata, 32'hFFFFFF80);
      check("l3_hold_err",   32'(obs_resp_err), 32'd0);
    end
    consume();

    // Reset during the second ACCESS cycle of a SW.
    @(negedge clk);
    w0 = wr_cnt[1];
    set_req(1'b1, 1'b1, 3'b010, 32'h30, 32'h11223344);
    @(posedge clk);
    #1;
    set_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    check("rst_mid_write_c1", 32'(obs_mem_write), 32'd1);
    @(negedge clk);
    rst3 = 1'b1;
    @(posedge clk);
    #1;
    rst3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_no_write", 32'(obs_mem_write), 32'd0);
      check("rst_mid_ready",    32'(obs_req_ready), 32'd1);
      check("rst_mid_valid",    32'(obs_resp_valid), 32'd0);
    end
    check("rst_mid_wcycles", 32'(wr_cnt[1] - w0), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
